// File: rtl/lab_alu_pkg.sv
// Shared types, button indices and combinational arithmetic helpers for lab_alu_seq.
// Helpers operate on MAXW-bit zero-extended operands; callers truncate to the live width.
package lab_alu_pkg;

  localparam int unsigned MAXW    = 64;
  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 3;
  localparam int unsigned BTN_R = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MULT,
    OP_LO,
    OP_NO,
    OP_ADD,
    OP_SUB
  } op_e;

  typedef enum logic {
    IDLE,
    MULT
  } state_e;

  function automatic logic [MAXW-1:0] count_ones(input logic [MAXW-1:0] v);
    logic [MAXW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      n = n + MAXW'(v[i]);
    end
    return n;
  endfunction

  // Counts the unbroken run of ones starting at bit w-1 (from_msb) or bit 0.
  function automatic logic [MAXW-1:0] lead_ones(input logic [MAXW-1:0] v,
                                                input int unsigned     w,
                                                input logic            from_msb);
    logic [MAXW-1:0] n;
    logic            run;
    int unsigned     pos;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < w) begin
        pos = from_msb ? (w - 1 - i) : i;
        run = run & v[pos];
        n   = n + MAXW'(run);
      end
    end
    return n;
  endfunction

  function automatic logic [MAXW-1:0] add_ext(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b);
    return a + b;
  endfunction

  // Full-width difference of zero-extended operands is already sign-extended.
  function automatic logic [MAXW-1:0] sub_ext(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchronizer, stable-count debouncer and
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNTW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = ~level_q;
      press_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lab_alu_seq.sv
// Button-driven sequential ALU: debounced presses select add/sub/count ops
// (one cycle) or a shift-add multiply (H cycles); result held on led.
module lab_alu_seq
  import lab_alu_pkg::*;
#(
  parameter int unsigned BITS            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter string       LO_FROM         = "MSB"
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic [BITS-1:0] sw,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] led,
  output logic            busy
);

  localparam int unsigned H      = BITS / 2;
  localparam int unsigned HP1    = H + 1;
  localparam int unsigned CW     = $clog2(BITS) + 1;
  localparam int unsigned IW     = $clog2(H);
  localparam logic        LO_MSB = (LO_FROM == "MSB");

  logic [NUM_BTN-1:0] btn_raw, press;

  assign btn_raw = {BTNR, BTNL, BTND, BTNU, BTNC};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i  (CLK100MHZ),
      .rst_ni (CPU_RESETN),
      .btn_i  (btn_raw[g]),
      .press_o(press[g])
    );
  end

  logic [MAXW-1:0] sw_ext, a_ext, b_ext;
  logic [BITS-1:0] res_lo, res_no, res_add, res_sub;
  op_e             op;

  assign sw_ext  = MAXW'(sw);
  assign a_ext   = MAXW'(sw[BITS-1:H]);
  assign b_ext   = MAXW'(sw[H-1:0]);
  assign res_lo  = BITS'(CW'(lead_ones(sw_ext, BITS, LO_MSB)));
  assign res_no  = BITS'(CW'(count_ones(sw_ext)));
  assign res_add = BITS'(HP1'(add_ext(a_ext, b_ext)));
  assign res_sub = BITS'(sub_ext(a_ext, b_ext));

  always_comb begin
    op = OP_NONE;
    if      (press[BTN_C]) op = OP_MULT;
    else if (press[BTN_U]) op = OP_LO;
    else if (press[BTN_D]) op = OP_NO;
    else if (press[BTN_L]) op = OP_ADD;
    else if (press[BTN_R]) op = OP_SUB;
  end

  state_e          state_q, state_d;
  logic [BITS-1:0] led_q, led_d;
  logic [BITS-1:0] mcand_q, mcand_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [H-1:0]    mplier_q, mplier_d;
  logic [IW-1:0]   iter_q, iter_d;

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    case (state_q)
      IDLE: begin
        case (op)
          OP_MULT: begin
            mcand_d  = BITS'(sw[BITS-1:H]);
            mplier_d = sw[H-1:0];
            acc_d    = '0;
            iter_d   = '0;
            state_d  = MULT;
          end
          OP_LO:   led_d = res_lo;
          OP_NO:   led_d = res_no;
          OP_ADD:  led_d = res_add;
          OP_SUB:  led_d = res_sub;
          default: ;
        endcase
      end
      MULT: begin
        // Final iteration's sum goes straight to led on the edge busy drops.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + IW'(1);
        if (iter_q == IW'(H - 1)) begin
          led_d   = acc_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= IDLE;
      led_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == MULT);

endmodule

// File: tb/tb_lab_alu_seq.sv
// Scoreboard bench for lab_alu_seq (BITS=16, DEBOUNCE_CYCLES=4): expected led
// values are queued at stimulus time and popped whenever led changes.
module tb_lab_alu_seq;

  localparam int unsigned BITS = 16;
  localparam int unsigned DB   = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [BITS-1:0] sw    = '0;
  logic            btnc  = 1'b0;
  logic            btnu  = 1'b0;
  logic            btnd  = 1'b0;
  logic            btnl  = 1'b0;
  logic            btnr  = 1'b0;
  logic [BITS-1:0] led;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [BITS-1:0] sb[$];
  logic [BITS-1:0] prev_led = '0;
  logic [BITS-1:0] mon_exp;

  always #5 clk = ~clk;

  lab_alu_seq #(
    .BITS           (BITS),
    .DEBOUNCE_CYCLES(DB),
    .LO_FROM        ("MSB")
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .sw        (sw),
    .BTNC      (btnc),
    .BTNU      (btnu),
    .BTND      (btnd),
    .BTNL      (btnl),
    .BTNR      (btnr),
    .led       (led),
    .busy      (busy)
  );

  // Every led change out of reset must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (led !== prev_led)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_led_change: got %h, required %h (nothing pending)", led, prev_led);
      end else begin
        mon_exp = sb.pop_front();
        if (led !== mon_exp) begin
          miscompares++;
          $display("FAIL led_result: got %h, required %h", led, mon_exp);
        end
      end
    end
    prev_led = led;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d results pending, required 0", name, sb.size());
      sb.delete();
    end
    cycles(1);
  endtask

  task automatic wait_busy(input logic level, input string name);
    int k;
    k = 0;
    while (busy !== level && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (busy !== level) begin
      miscompares++;
      $display("FAIL %s: got busy=%b, required %b", name, busy, level);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycles(3);
    vectors++;
    if (led !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got led=%h busy=%b, required led=0000 busy=0", led, busy);
    end
    rst_n = 1'b1;
    cycles(20);
    vectors++;
    if (led !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h, required 0000", led);
    end
  endtask

  task automatic test_bounce;
    sw = 16'h0C05;
    for (int i = 0; i < 10; i++) begin
      btnl = ~btnl;
      cycles(2);
    end
    sb.push_back(16'h0011);
    btnl = 1'b1;
    cycles(12);
    btnl = 1'b0;
    cycles(12);
    drain("bounce_add");
    sw = 16'h0305;
    sb.push_back(16'hFFFE);
    btnr = 1'b1;
    cycles(12);
    btnr = 1'b0;
    cycles(12);
    drain("sub");
  endtask

  task automatic test_mult;
    int n;
    sw = 16'hFFFF;
    sb.push_back(16'hFE01);
    btnc = 1'b1;
    wait_busy(1'b1, "mult_busy_rise");
    sw = 16'h0000;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL mult_busy_cycles: got %0d, required 8", n);
    end
    vectors++;
    if (led !== 16'hFE01) begin
      miscompares++;
      $display("FAIL mult_led_at_busy_fall: got %h, required fe01", led);
    end
    btnc = 1'b0;
    cycles(12);
    drain("mult");
  endtask

  task automatic test_counts;
    sw = 16'hF0F0;
    sb.push_back(16'h0004);
    btnu = 1'b1; cycles(12); btnu = 1'b0; cycles(12);
    drain("lead_ones");
    sb.push_back(16'h0008);
    btnd = 1'b1; cycles(12); btnd = 1'b0; cycles(12);
    drain("num_ones");
    sw = 16'hFFFF;
    sb.push_back(16'h0010);
    btnu = 1'b1; cycles(12); btnu = 1'b0; cycles(12);
    drain("lead_ones_all");
  endtask

  task automatic test_simultaneous;
    sw = 16'h0C05;
    sb.push_back(16'h0011);
    btnl = 1'b1;
    btnr = 1'b1;
    cycles(12);
    btnl = 1'b0;
    btnr = 1'b0;
    cycles(20);
    drain("simultaneous");
    vectors++;
    if (led !== 16'h0011) begin
      miscompares++;
      $display("FAIL simultaneous_final: got %h, required 0011", led);
    end
  endtask

  task automatic test_ignore_busy;
    sw = 16'h0302;
    sb.push_back(16'h0006);
    btnc = 1'b1;
    cycles(2);
    btnl = 1'b1;
    wait_busy(1'b1, "ignore_busy_rise");
    wait_busy(1'b0, "ignore_busy_fall");
    cycles(10);
    btnc = 1'b0;
    btnl = 1'b0;
    cycles(20);
    drain("ignore_busy");
    vectors++;
    if (led !== 16'h0006) begin
      miscompares++;
      $display("FAIL ignore_busy_final: got %h, required 0006", led);
    end
  endtask

  task automatic test_reset_mid_mult;
    sw = 16'hFFFF;
    btnc = 1'b1;
    wait_busy(1'b1, "reset_mult_busy_rise");
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (led !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mult: got led=%h busy=%b, required led=0000 busy=0", led, busy);
    end
    btnc = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    vectors++;
    if (led !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_mid_mult: got led=%h busy=%b, required led=0000 busy=0", led, busy);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_mult();
    test_counts();
    test_simultaneous();
    test_ignore_busy();
    test_reset_mid_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within 1ms");
    $fatal(1);
  end

endmodule
